// File: rtl/vga_pkg.sv
// Shared raster definitions: field widths for vga_if and the 1024x768@60 timing constants.
package vgaPkg;

  localparam int unsigned CNT_W = 11;
  localparam int unsigned RGB_W = 12;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [RGB_W-1:0] rgb_t;

  localparam cnt_t HOR_PIXELS     = 11'd1024;
  localparam cnt_t HOR_TOTAL      = 11'd1344;
  localparam cnt_t HOR_SYNC_START = 11'd1048;
  localparam cnt_t HOR_SYNC_STOP  = 11'd1183;

  localparam cnt_t VER_PIXELS     = 11'd768;
  localparam cnt_t VER_TOTAL      = 11'd806;
  localparam cnt_t VER_SYNC_START = 11'd771;
  localparam cnt_t VER_SYNC_STOP  = 11'd776;

  localparam rgb_t RGB_BLACK = 12'h000;

endpackage

// File: rtl/vga_if.sv
// Raster stream passed along the draw chain: counters, sync/blank flags and pixel colour.
interface vga_if;
  import vgaPkg::*;

  cnt_t hcount;
  logic hsync;
  logic hblnk;
  cnt_t vcount;
  logic vsync;
  logic vblnk;
  rgb_t rgb;

  modport out    (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
  modport master (output hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);
  modport slave  (input  hcount, hsync, hblnk, vcount, vsync, vblnk, rgb);

endinterface

// File: rtl/vga_timing.sv
// Free-running raster timing generator: pixel/line counters, sync/blank decode,
// one registered output stage, and a frame tick/counter for animation pacing.
module vga_timing #(
  parameter int unsigned  FRAME_CNT_W    = 16,
  parameter vgaPkg::cnt_t HOR_PIXELS     = vgaPkg::HOR_PIXELS,
  parameter vgaPkg::cnt_t HOR_TOTAL      = vgaPkg::HOR_TOTAL,
  parameter vgaPkg::cnt_t HOR_SYNC_START = vgaPkg::HOR_SYNC_START,
  parameter vgaPkg::cnt_t HOR_SYNC_STOP  = vgaPkg::HOR_SYNC_STOP,
  parameter vgaPkg::cnt_t VER_PIXELS     = vgaPkg::VER_PIXELS,
  parameter vgaPkg::cnt_t VER_TOTAL      = vgaPkg::VER_TOTAL,
  parameter vgaPkg::cnt_t VER_SYNC_START = vgaPkg::VER_SYNC_START,
  parameter vgaPkg::cnt_t VER_SYNC_STOP  = vgaPkg::VER_SYNC_STOP
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_if.out                     out,
  output logic                   frame_tick,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam int unsigned CW = vgaPkg::CNT_W;

  vgaPkg::cnt_t h_cnt;
  vgaPkg::cnt_t v_cnt;
  logic         h_last;
  logic         v_last;
  logic         frame_start;
  logic         armed;

  always_comb begin
    h_last      = (h_cnt == HOR_TOTAL - CW'(1));
    v_last      = (v_cnt == VER_TOTAL - CW'(1));
    frame_start = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_last ? '0 : h_cnt + CW'(1);
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + CW'(1);
      end
    end
  end

  // Every output field, the tick included, is sampled from the same counter
  // state so the stream stays coherent with exactly one cycle of latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      out.hcount <= '0;
      out.vcount <= '0;
      out.hsync  <= 1'b0;
      out.hblnk  <= 1'b0;
      out.vsync  <= 1'b0;
      out.vblnk  <= 1'b0;
      out.rgb    <= '0;
    end else begin
      out.hcount <= h_cnt;
      out.vcount <= v_cnt;
      out.hblnk  <= (h_cnt >= HOR_PIXELS);
      out.hsync  <= (h_cnt >= HOR_SYNC_START) && (h_cnt <= HOR_SYNC_STOP);
      out.vblnk  <= (v_cnt >= VER_PIXELS);
      out.vsync  <= (v_cnt >= VER_SYNC_START) && (v_cnt <= VER_SYNC_STOP);
      out.rgb    <= vgaPkg::RGB_BLACK;
    end
  end

  // The first frame start after reset only arms the tick; it does not count
  // as a completed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      armed      <= 1'b0;
      frame_tick <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      frame_tick <= frame_start && armed;
      if (frame_start) begin
        armed <= 1'b1;
        if (armed) begin
          frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench: full-timing instance for horizontal behaviour and reset, plus a
// reduced-timing instance so line/frame wraps and frame counter wrap fit a short run.
module tb_vga_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;

  vga_if vif();
  vga_if vif_s();

  logic        frame_tick;
  logic [15:0] frame_cnt;
  logic        frame_tick_s;
  logic [1:0]  frame_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vga_timing dut (
    .clk        (clk),
    .rst        (rst),
    .out        (vif),
    .frame_tick (frame_tick),
    .frame_cnt  (frame_cnt)
  );

  // Reduced raster: 24 px/line (16 visible, sync 18..20), 12 lines (8 visible, sync 9..10).
  vga_timing #(
    .FRAME_CNT_W    (2),
    .HOR_PIXELS     (11'd16),
    .HOR_TOTAL      (11'd24),
    .HOR_SYNC_START (11'd18),
    .HOR_SYNC_STOP  (11'd20),
    .VER_PIXELS     (11'd8),
    .VER_TOTAL      (11'd12),
    .VER_SYNC_START (11'd9),
    .VER_SYNC_STOP  (11'd10)
  ) dut_s (
    .clk        (clk),
    .rst        (rst_s),
    .out        (vif_s),
    .frame_tick (frame_tick_s),
    .frame_cnt  (frame_cnt_s)
  );

  task automatic test_reset();
    logic [37:0] obs;
    rst   = 1'b1;
    rst_s = 1'b1;
    repeat (3) @(negedge clk);
    obs = {vif.hcount, vif.vcount, vif.hsync, vif.hblnk, vif.vsync, vif.vblnk, vif.rgb};
    n_checks++;
    if (obs !== 38'h0) begin
      n_fail++;
      $display("FAIL reset_out: got %h want %h", obs, 38'h0);
    end
    n_checks++;
    if ({frame_tick, frame_cnt} !== 17'h0) begin
      n_fail++;
      $display("FAIL reset_frame: tick=%b cnt=%0d want 0/0", frame_tick, frame_cnt);
    end
    obs = {vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.hblnk, vif_s.vsync, vif_s.vblnk, vif_s.rgb};
    n_checks++;
    if (obs !== 38'h0 || frame_tick_s !== 1'b0 || frame_cnt_s !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_small: got %h tick=%b cnt=%0d want all 0", obs, frame_tick_s, frame_cnt_s);
    end
  endtask

  // Release reset and walk one full line plus the first pixel of the next.
  task automatic test_hcount();
    logic [37:0] obs, exp;
    int hs_cycles = 0;
    int blnk_rise = -1;
    logic prev_blnk = 1'b0;
    rst = 1'b0;
    for (int k = 0; k <= 1344; k++) begin
      int eh, ev;
      @(negedge clk);
      eh  = k % 1344;
      ev  = k / 1344;
      exp = {11'(eh), 11'(ev), (eh >= 1048 && eh <= 1183), (eh >= 1024), 1'b0, 1'b0, 12'h000};
      obs = {vif.hcount, vif.vcount, vif.hsync, vif.hblnk, vif.vsync, vif.vblnk, vif.rgb};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL hline k=%0d: got %h want %h", k, obs, exp);
      end
      n_checks++;
      if (frame_tick !== 1'b0 || frame_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL hline_tick k=%0d: tick=%b cnt=%0d want 0/0", k, frame_tick, frame_cnt);
      end
      if (k < 1344 && vif.hsync === 1'b1) hs_cycles++;
      if (vif.hblnk === 1'b1 && prev_blnk === 1'b0 && blnk_rise < 0) blnk_rise = int'(vif.hcount);
      prev_blnk = vif.hblnk;
    end
    n_checks++;
    if (hs_cycles != 136) begin
      n_fail++;
      $display("FAIL hsync_width: got %0d want 136", hs_cycles);
    end
    n_checks++;
    if (blnk_rise != 1024) begin
      n_fail++;
      $display("FAIL hblnk_rise: got %0d want 1024", blnk_rise);
    end
  endtask

  // Continues from (0,1): step to (500,1), pulse reset for one cycle.
  task automatic test_mid_reset_full();
    logic [37:0] obs;
    repeat (500) @(negedge clk);
    n_checks++;
    if (vif.hcount !== 11'd500 || vif.vcount !== 11'd1) begin
      n_fail++;
      $display("FAIL midrst_pos: got (%0d,%0d) want (500,1)", vif.hcount, vif.vcount);
    end
    rst = 1'b1;
    @(negedge clk);
    obs = {vif.hcount, vif.vcount, vif.hsync, vif.hblnk, vif.vsync, vif.vblnk, vif.rgb};
    n_checks++;
    if (obs !== 38'h0 || frame_tick !== 1'b0 || frame_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_zero: got %h tick=%b cnt=%0d want all 0", obs, frame_tick, frame_cnt);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (vif.hcount !== 11'(k) || vif.vcount !== 11'd0) begin
        n_fail++;
        $display("FAIL midrst_restart k=%0d: got (%0d,%0d) want (%0d,0)", k, vif.hcount, vif.vcount, k);
      end
    end
  endtask

  // Five reduced frames: every field per cycle, wraps, vsync width, counter wrap.
  task automatic test_frames();
    logic [37:0] obs, exp;
    int vs_cycles = 0;
    int n_ticks = 0;
    logic [1:0] tick_cnt [5];
    logic [1:0] want_cnt [5];
    want_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    rst_s = 1'b0;
    for (int k = 0; k <= 1440; k++) begin
      int eh, ev;
      logic et;
      @(negedge clk);
      eh  = k % 24;
      ev  = (k / 24) % 12;
      et  = (k > 0) && (k % 288 == 0);
      exp = {11'(eh), 11'(ev), (eh >= 18 && eh <= 20), (eh >= 16),
             (ev >= 9 && ev <= 10), (ev >= 8), 12'h000};
      obs = {vif_s.hcount, vif_s.vcount, vif_s.hsync, vif_s.hblnk, vif_s.vsync, vif_s.vblnk, vif_s.rgb};
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL frame k=%0d: got %h want %h", k, obs, exp);
      end
      n_checks++;
      if (frame_tick_s !== et || frame_cnt_s !== 2'((k / 288) % 4)) begin
        n_fail++;
        $display("FAIL frame_tick k=%0d: tick=%b cnt=%0d want %b/%0d", k, frame_tick_s, frame_cnt_s, et, (k / 288) % 4);
      end
      if (k == 192) begin
        n_checks++;
        if (vif_s.hcount !== 11'd0 || vif_s.vcount !== 11'd8 || vif_s.vblnk !== 1'b1) begin
          n_fail++;
          $display("FAIL line_wrap: got (%0d,%0d) vblnk=%b want (0,8) 1", vif_s.hcount, vif_s.vcount, vif_s.vblnk);
        end
      end
      if (k == 288) begin
        n_checks++;
        if (vif_s.hcount !== 11'd0 || vif_s.vcount !== 11'd0 || vif_s.vblnk !== 1'b0 || frame_tick_s !== 1'b1) begin
          n_fail++;
          $display("FAIL frame_wrap: got (%0d,%0d) vblnk=%b tick=%b want (0,0) 0 1",
                   vif_s.hcount, vif_s.vcount, vif_s.vblnk, frame_tick_s);
        end
      end
      if (k < 288 && vif_s.vsync === 1'b1) vs_cycles++;
      if (frame_tick_s === 1'b1 && n_ticks < 5) begin
        tick_cnt[n_ticks] = frame_cnt_s;
        n_ticks++;
      end
    end
    n_checks++;
    if (vs_cycles != 2 * 24) begin
      n_fail++;
      $display("FAIL vsync_width: got %0d cycles want 48", vs_cycles);
    end
    n_checks++;
    if (n_ticks != 5) begin
      n_fail++;
      $display("FAIL tick_count: got %0d want 5", n_ticks);
    end
    for (int i = 0; i < n_ticks; i++) begin
      n_checks++;
      if (tick_cnt[i] !== want_cnt[i]) begin
        n_fail++;
        $display("FAIL cnt_wrap[%0d]: got %0d want %0d", i, tick_cnt[i], want_cnt[i]);
      end
    end
  endtask

  // Reduced instance sits at (0,0) with frame_cnt=1; abort the frame at (10,5).
  task automatic test_mid_reset_small();
    repeat (130) @(negedge clk);
    n_checks++;
    if (vif_s.hcount !== 11'd10 || vif_s.vcount !== 11'd5 || frame_cnt_s !== 2'd1) begin
      n_fail++;
      $display("FAIL abort_pos: got (%0d,%0d) cnt=%0d want (10,5) 1", vif_s.hcount, vif_s.vcount, frame_cnt_s);
    end
    rst_s = 1'b1;
    @(negedge clk);
    n_checks++;
    if (vif_s.hcount !== 11'd0 || vif_s.vcount !== 11'd0 || frame_tick_s !== 1'b0 || frame_cnt_s !== 2'd0) begin
      n_fail++;
      $display("FAIL abort_zero: got (%0d,%0d) tick=%b cnt=%0d want all 0",
               vif_s.hcount, vif_s.vcount, frame_tick_s, frame_cnt_s);
    end
    rst_s = 1'b0;
    for (int k = 0; k <= 288; k++) begin
      logic et;
      @(negedge clk);
      et = (k == 288);
      n_checks++;
      if (vif_s.hcount !== 11'(k % 24) || vif_s.vcount !== 11'((k / 24) % 12) ||
          frame_tick_s !== et || frame_cnt_s !== 2'(et)) begin
        n_fail++;
        $display("FAIL abort_restart k=%0d: got (%0d,%0d) tick=%b cnt=%0d want (%0d,%0d) %b %0d",
                 k, vif_s.hcount, vif_s.vcount, frame_tick_s, frame_cnt_s,
                 k % 24, (k / 24) % 12, et, et);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_hcount();
    test_mid_reset_full();
    test_frames();
    test_mid_reset_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameter FRAME_CNT_W, default 16, width of the free-running frame counter.
REQ-002 clk  input  1  pixel clock, 65 MHz, one pixel per cycle.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 out  vga_if.out  (hcount 11, hsync 1, hblnk 1, vcount 11, vsync 1, vblnk 1, rgb 12)  raster stream source for the draw chain.
REQ-005 frame_tick  output  1  one-cycle pulse marking the first pixel of each frame.
REQ-006 frame_cnt  output  FRAME_CNT_W  number of frames completed since reset, for sprite animation pacing.

Function
REQ-007 The block SHALL keep internal counters h_cnt (0..HOR_TOTAL-1) and v_cnt (0..VER_TOTAL-1), both 11 bits.
REQ-008 The timing SHALL be 1024x768@60: HOR_PIXELS 1024, HOR_TOTAL 1344, HOR_SYNC_START 1048, HOR_SYNC_STOP 1183; VER_PIXELS 768, VER_TOTAL 806, VER_SYNC_START 771, VER_SYNC_STOP 776.
REQ-009 h_cnt SHALL increment every cycle and wrap from 1343 to 0.
REQ-010 v_cnt SHALL increment only on the cycle h_cnt wraps, and SHALL wrap from 805 to 0 on that same cycle.
REQ-011 The block SHALL derive hblnk = (h_cnt >= 1024), hsync = (1048 <= h_cnt <= 1183), vblnk = (v_cnt >= 768) and vsync = (771 <= v_cnt <= 776); sync SHALL be 1 during the sync interval, with polarity inversion done at the pad.
REQ-012 All out.* fields SHALL be registered, with exactly 1 cycle of latency from the counter state they describe; all fields SHALL come from the same counter state in the same cycle.
REQ-013 out.rgb SHALL be constant 12'h000; downstream draw stages overwrite it.
REQ-014 frame_tick SHALL be registered and SHALL be 1 exactly in the cycle where out.hcount==0 and out.vcount==0, except in the first such cycle after reset.
REQ-015 frame_cnt SHALL increment by 1 in the same cycle frame_tick is 1, and SHALL wrap modulo 2^FRAME_CNT_W with no saturation.
REQ-016 The horizontal wrap and the vertical wrap at (1343, 805) SHALL occur in the same cycle, so the next state is (0, 0).
REQ-017 The block SHALL have no enable and no stall; the stream never pauses.

Reset
REQ-018 While rst=1, h_cnt, v_cnt, all out.* fields, frame_tick and frame_cnt SHALL be 0.
REQ-019 In the first cycle after rst falls, out SHALL present hcount=0 and vcount=0; hcount 1 SHALL follow in the next cycle.
REQ-020 If rst is asserted mid-frame, the next edge SHALL force all state to 0 regardless of counter position, and no frame_tick SHALL be emitted for the aborted frame.

Structure
REQ-021 All timing constants in REQ-008 SHALL be localparams in vgaPkg, beside the existing VER_PIXELS.
REQ-022 vgaPkg SHALL own the vga_if field widths (11-bit counts, 12-bit rgb).
REQ-023 The design SHALL be a single module with no sub-modules; the counters, decode and output register stage all live in vga_timing.

Verification
REQ-024 Release rst at cycle 0 -> out.hcount sequence 0,1,2...; out.hblnk rises at out.hcount=1024; out.hsync is 1 for out.hcount 1048..1183, which is 136 cycles.
REQ-025 Run 2 full frames (2,166,528 cycles) -> exactly 1 frame_tick, frame_cnt=1; the tick occurs at cycle 1,083,264 after release.
REQ-026 Line wrap: at out.hcount=1343 with out.vcount=767 -> next cycle shows hcount=0, vcount=768 and vblnk=1.
REQ-027 Frame wrap: at out (1343, 805) -> next cycle shows (0, 0) with frame_tick=1 and vblnk=0; vsync is 1 only for vcount 771..776, which is 6 lines.
REQ-028 Assert rst for 1 cycle at out (500, 300) -> the next cycle shows all outputs 0, frame_cnt stays 0, and counting restarts at 0.
REQ-029 With FRAME_CNT_W=2, run 5 frames -> frame_cnt goes 1,2,3,0 and wraps with no glitch.
